bounce_emulator: RTL and testbench

BOUNCE_EMULATOR -- requirements
Module: bounce_emulator

---
 rtl/bounce_emu_pkg.sv | 21 ++
 rtl/lfsr16.sv | 24 ++
 rtl/bounce_emulator.sv | 142 ++++++++++++++
 tb/tb_bounce_emulator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_emu_pkg.sv
// Shared definitions for the bounce emulator: FSM state encoding, LFSR
// feedback taps and the settle-counter width.
package bounce_emu_pkg;

  typedef enum logic [1:0] {
    STABLE = 2'b00,
    BOUNCE = 2'b01,
    SETTLE = 2'b10
  } state_e;

  // Fibonacci taps 16,14,13,11 expressed as a bit mask over q[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int SETTLE_W = 24;

  // XOR of all tapped bits gives the bit shifted in at the bottom
  function automatic logic lfsr_feedback(input logic [15:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that free-runs every cycle; reloads seed on reset.
module lfsr16
  import bounce_emu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;

  // Shift left, inserting the tap parity at bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= seed;
    end else begin
      q_q <= {q_q[14:0], lfsr_feedback(q_q)};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bounce_emulator.sv
// Mechanical switch bounce emulator. A change on cmd produces BOUNCES
// toggles of sw spaced by an interval, then sw is held at the target for
// SETTLE_CYC cycles before a one-cycle done_tick.
// Build option: define BOUNCE_LFSR_EN to draw pseudo-random intervals from a
// 16-bit LFSR; otherwise every interval is 2^(INTERVAL_W-1).
module bounce_emulator
  import bounce_emu_pkg::*;
#(
  parameter int          BOUNCES    = 8,
  parameter int          INTERVAL_W = 12,
  parameter int          SETTLE_CYC = 65536,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd,
  output logic sw,
  output logic busy,
  output logic done_tick
);

  localparam logic [INTERVAL_W-1:0] IVL_ONE     = {{(INTERVAL_W-1){1'b0}}, 1'b1};
  localparam logic [SETTLE_W-1:0]   SETTLE_ONE  = {{(SETTLE_W-1){1'b0}}, 1'b1};
  localparam logic [SETTLE_W-1:0]   SETTLE_LOAD = SETTLE_W'(SETTLE_CYC);
  localparam logic [7:0]            BOUNCE_LAST = 8'(BOUNCES);

  state_e                state_q, state_d;
  logic                  target_q, target_d;
  logic                  sw_q, sw_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [INTERVAL_W-1:0] ivl_q, ivl_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [INTERVAL_W-1:0] new_ivl;

`ifdef BOUNCE_LFSR_EN
  logic [15:0] lfsr_q;
  logic        lfsr_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q;

  // Take the low LFSR bits as the next interval, never allowing zero
  always_comb begin
    new_ivl = lfsr_q[INTERVAL_W-1:0];
    if (new_ivl == '0) begin
      new_ivl = IVL_ONE;
    end
  end
`else
  localparam logic [INTERVAL_W-1:0] FIXED_IVL = {1'b1, {(INTERVAL_W-1){1'b0}}};

  assign new_ivl = FIXED_IVL;
`endif

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= STABLE;
      target_q <= 1'b0;
      sw_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      ivl_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sw_q     <= sw_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      ivl_q    <= ivl_d;
      settle_q <= settle_d;
    end
  end

  // Next-state logic; a new target always wins and restarts the bounce
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sw_d     = sw_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    ivl_d    = ivl_q;
    settle_d = settle_q;

    if (cmd != target_q) begin
      sw_d     = ~sw_q;
      target_d = cmd;
      cnt_d    = 8'd1;
      ivl_d    = new_ivl;
      busy_d   = 1'b1;
      state_d  = BOUNCE;
    end else begin
      unique case (state_q)
        STABLE: begin
        end
        BOUNCE: begin
          if (ivl_q > IVL_ONE) begin
            ivl_d = ivl_q - IVL_ONE;
          end else if (cnt_q < BOUNCE_LAST) begin
            sw_d  = ~sw_q;
            cnt_d = cnt_q + 8'd1;
            ivl_d = new_ivl;
          end else begin
            sw_d     = target_q;
            settle_d = SETTLE_LOAD;
            state_d  = SETTLE;
          end
        end
        SETTLE: begin
          sw_d = target_q;
          if (settle_q > SETTLE_ONE) begin
            settle_d = settle_q - SETTLE_ONE;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = STABLE;
          end
        end
        default: begin
          state_d = STABLE;
        end
      endcase
    end
  end

  assign sw        = sw_q;
  assign busy      = busy_q;
  assign done_tick = done_q;

endmodule

// File: tb/tb_bounce_emulator.sv
// Testbench for bounce_emulator. The reference model schedules each
// transition as a list of absolute toggle cycles plus force and done cycles,
// derived from the interval rules. Build with BOUNCE_LFSR_EN to exercise
// the LFSR interval source.
module tb_bounce_emulator;

  localparam int          BOUNCES    = 4;
  localparam int          INTERVAL_W = 4;
  localparam int          SETTLE_CYC = 16;
  localparam logic [15:0] SEED       = 16'hACE1;
  localparam int          MAXN       = 8192;
  localparam int          FILTER     = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cmd = 1'b0;
  logic sw, busy, done_tick;

  bounce_emulator #(
    .BOUNCES    (BOUNCES),
    .INTERVAL_W (INTERVAL_W),
    .SETTLE_CYC (SETTLE_CYC),
    .SEED       (SEED)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd),
    .sw        (sw),
    .busy      (busy),
    .done_tick (done_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [15:0] lfsrSeq [MAXN];
  logic        swHist [MAXN];
  logic        busyHist [MAXN];
  logic        doneHist [MAXN];

  logic mSw, mTarget, mBusy, mDone;
  int   evQ[$];
  int   forceAt, doneAt;
  int   n;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int ivlAt(input int t);
`ifdef BOUNCE_LFSR_EN
    int v;
    v = int'(lfsrSeq[t]) % (1 << INTERVAL_W);
    return (v == 0) ? 1 : v;
`else
    return 1 << (INTERVAL_W - 1);
`endif
  endfunction

  task automatic modelStep(input logic c);
    int t;
    mDone = 1'b0;
    if (c != mTarget) begin
      mTarget = c;
      mSw     = ~mSw;
      mBusy   = 1'b1;
      evQ.delete();
      t = n;
      for (int k = 1; k < BOUNCES; k++) begin
        t = t + ivlAt(t);
        evQ.push_back(t);
      end
      forceAt = t + ivlAt(t);
      doneAt  = forceAt + SETTLE_CYC;
    end else if (mBusy) begin
      if (evQ.size() > 0 && evQ[0] == n) begin
        mSw = ~mSw;
        evQ.delete(0);
      end else if (n == forceAt) begin
        mSw = mTarget;
      end else if (n == doneAt) begin
        mDone = 1'b1;
        mBusy = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic c);
    int run;
    cmd = c;
    @(posedge clk);
    modelStep(c);
    @(negedge clk);
    checkOutput("sw", 32'(sw), 32'(mSw));
    checkOutput("busy", 32'(busy), 32'(mBusy));
    checkOutput("done", 32'(done_tick), 32'(mDone));
    swHist[n]   = sw;
    busyHist[n] = busy;
    doneHist[n] = done_tick;
    if (done_tick === 1'b1) begin
      run = 0;
      for (int i = n; i > 0 && run <= SETTLE_CYC; i--) begin
        if (swHist[i-1] !== swHist[n]) break;
        run++;
      end
      checkOutput("settleRun", 32'(run >= SETTLE_CYC), 32'd1);
    end
    n++;
  endtask

  task automatic applyReset(input int cyc);
    rst_n = 1'b0;
    cmd   = 1'b0;
    #1;
    checkOutput("rstSw", 32'(sw), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done_tick), 32'd0);
    repeat (cyc) @(negedge clk);
    rst_n   = 1'b1;
    mSw     = 1'b0;
    mTarget = 1'b0;
    mBusy   = 1'b0;
    mDone   = 1'b0;
    evQ.delete();
    forceAt = -1;
    doneAt  = -1;
    n       = 0;
  endtask

  function automatic int countDone(input int first, input int last);
    int c;
    c = 0;
    for (int i = first; i <= last; i++) c += int'(doneHist[i]);
    return c;
  endfunction

  function automatic int debChanges(input int first, input int last, input logic initLvl);
    logic lvl;
    int   run, chg;
    lvl = initLvl;
    run = 0;
    chg = 0;
    for (int i = first; i <= last; i++) begin
      if (swHist[i] != lvl) begin
        run++;
        if (run >= FILTER) begin
          lvl = ~lvl;
          chg++;
          run = 0;
        end
      end else begin
        run = 0;
      end
    end
    return chg;
  endfunction

  initial begin
    logic c;
    int   hold, e0, e1, act;

    lfsrSeq[0] = SEED;
    for (int i = 1; i < MAXN; i++) begin
      lfsrSeq[i] = {lfsrSeq[i-1][14:0],
                    lfsrSeq[i-1][15] ^ lfsrSeq[i-1][13] ^ lfsrSeq[i-1][12] ^ lfsrSeq[i-1][10]};
    end

    @(negedge clk);
    applyReset(2);

`ifndef BOUNCE_LFSR_EN
    repeat (100) applyStimulus(1'b0);
    act = 0;
    for (int i = 0; i < 100; i++) act += int'(swHist[i] | busyHist[i] | doneHist[i]);
    checkOutput("idleActivity", 32'(act), 32'd0);

    e0 = n;
    repeat (60) applyStimulus(1'b1);
    checkOutput("e0Sw", 32'(swHist[e0]), 32'd1);
    checkOutput("e0Busy", 32'(busyHist[e0]), 32'd1);
    checkOutput("e7Sw", 32'(swHist[e0+7]), 32'd1);
    checkOutput("e8Sw", 32'(swHist[e0+8]), 32'd0);
    checkOutput("e16Sw", 32'(swHist[e0+16]), 32'd1);
    checkOutput("e24Sw", 32'(swHist[e0+24]), 32'd0);
    checkOutput("e32Sw", 32'(swHist[e0+32]), 32'd1);
    checkOutput("e47Done", 32'(doneHist[e0+47]), 32'd0);
    checkOutput("e48Done", 32'(doneHist[e0+48]), 32'd1);
    checkOutput("e49Done", 32'(doneHist[e0+49]), 32'd0);
    checkOutput("e47Busy", 32'(busyHist[e0+47]), 32'd1);
    checkOutput("e48Busy", 32'(busyHist[e0+48]), 32'd0);
    checkOutput("debBounce", 32'(debChanges(e0, e0 + 31, 1'b0)), 32'd0);
    checkOutput("debTotal", 32'(debChanges(e0, e0 + 59, 1'b0)), 32'd1);

    applyReset(2);
    e0 = n;
    repeat (12) applyStimulus(1'b1);
    repeat (70) applyStimulus(1'b0);
    checkOutput("firstEdgeSw", 32'(swHist[e0]), 32'd1);
    checkOutput("rtPreSw", 32'(swHist[e0+11]), 32'd0);
    checkOutput("rtSw", 32'(swHist[e0+12]), 32'd1);
    checkOutput("rtDoneAt", 32'(doneHist[e0+60]), 32'd1);
    checkOutput("rtDoneCnt", 32'(countDone(e0, e0 + 81)), 32'd1);
    checkOutput("rtFinalSw", 32'(swHist[e0+81]), 32'd0);

    e0 = n;
    repeat (20) applyStimulus(1'b1);
    checkOutput("preRstSw", 32'(swHist[e0+19]), 32'd1);
    applyReset(2);
    e1 = n;
    repeat (100) applyStimulus(1'b0);
    checkOutput("rstNoDone", 32'(countDone(e1, e1 + 99)), 32'd0);
`endif

    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 14) == 0 || n > MAXN - 300) applyReset(int'($urandom_range(1, 3)));
      c = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : int'($urandom_range(50, 110));
      repeat (hold) applyStimulus(c);
    end
    c = ~mTarget;
    e0 = n;
    repeat (120) applyStimulus(c);
    checkOutput("finalDoneCnt", 32'(countDone(e0, e0 + 119)), 32'd1);
    checkOutput("finalDeb", 32'(debChanges(e0, e0 + 119, ~c)), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
